dendrite_compartment: RTL and testbench
=======================================

// Module: dendrite_compartment
// PURPOSE
// - Passive/active dendritic compartment directly downstream of NUM_SYN synapse blocks.
// - Sums the synapses' output_current and integrates it with a leak into membrane potential vmem.
// - Drives vmem back to every synapse; the synapses use it for their reversal-potential term.
// - Optional plateau FSM: emits a one-cycle dendritic spike and clamps vmem for a configured
//   number of cycles, then holds it for a refractory period.
// PARAMETERS
// - NUM_SYN        4   number of attached synapse_dendrite_if ports
// - LEAK_SHIFT     10  arithmetic right shift applied to g_leak*(E_l-vmem)
// - CURRENT_SHIFT  4   arithmetic right shift applied to the summed synaptic current
// PORTS
// - clk             in   1       system clock
// - reset           in   1       synchronous, active-high
// - syn[NUM_SYN]    -    if      synapse_dendrite_if.dendrite array
//                                - reads output_current (fp::WORD_LENGTH, signed)
//                                - drives vmem
// - cfg_in          -    if      config_if.slave; configuration shift-chain input
// - cfg_out         -    if      config_if.master; configuration shift-chain output
// - vmem_out        out  16      registered vmem, signed fp::fpType, to soma
// - dendritic_spike out  1       one-cycle pulse on plateau entry
// BEHAVIOUR
// - All arithmetic is signed two's complement; fp::WORD_LENGTH = 16.
// - Reset values: vmem=0, vmem_out=0, syn[*].vmem=0, i_sum_q=0, dendritic_spike=0,
//   state=IDLE, counter=0. Reset has priority over every other event.
// - Stage 1: i_sum_q <= sum of syn[k].output_current, each sign-extended.
//   Width is 16+$clog2(NUM_SYN); the sum is exact and never wraps.
// - Stage 2 (IDLE only):
//   - vmem_next = vmem + ((g_leak*(E_l-vmem))>>>LEAK_SHIFT) + (i_sum_q>>>CURRENT_SHIFT)
//   - g_leak is unsigned 16b, multiplied as 17b {0,g_leak}; E_l-vmem is computed 17b.
//   - Intermediates are full width; the result saturates to 0x7FFF / 0x8000 and never wraps.
// - Latency: a current change at a synapse first affects vmem 2 clk edges later.
// - vmem_out and syn[*].vmem equal the vmem register; there is no extra delay.
// - FSM (present only with DENDRITE_PLATEAU_EN):
//   - IDLE: integrate as above.
//     - If registered vmem >= v_thresh (signed):
//       - go to PLATEAU, vmem <= v_plateau, counter <= t_plateau;
//       - dendritic_spike=1 for that cycle only.
//   - PLATEAU: vmem held at v_plateau; synaptic input ignored; counter decrements.
//     - When counter<=1: go to REFRACT, vmem <= E_l, counter <= t_refrac.
//     - A t value of 0 or 1 means one cycle in the state.
//   - REFRACT: vmem held at E_l; input ignored; counter decrements.
//     - When counter<=1: go to IDLE; integration resumes the next cycle from E_l.
//   - The threshold is not re-evaluated in PLATEAU or REFRACT; there is no re-trigger.
//   - Stage 1 keeps running in every state; i_sum_q is simply not used outside IDLE.
// - Reset mid-PLATEAU/REFRACT: next edge gives state IDLE, vmem 0, counter 0, spike 0.
// CONFIGURATION
// - Shift chain clocked on cfg_in.data_clk; cfg_out.data_clk = cfg_in.data_clk.
// - Order: cfg_in.data_in -> E_l -> g_leak -> v_thresh -> v_plateau -> t_plateau
//   -> t_refrac -> cfg_out.data_in.
// - Six 16b words, in both builds, so chain length never depends on the macro.
// - Configuration is changed only while reset is asserted; runtime changes are unsupported.
// - Optional feature, macro DENDRITE_PLATEAU_EN:
//   - Defined: FSM as above.
//   - Undefined: no FSM; pure leaky integrator in permanent IDLE; dendritic_spike tied to 0;
//     v_thresh, v_plateau, t_plateau and t_refrac are still shifted but unused.
// TESTING (NUM_SYN=4, LEAK_SHIFT=10, CURRENT_SHIFT=4)
// 1. Reset held 2 cycles with all currents 0x0100
//    -> vmem_out=0, dendritic_spike=0, state IDLE throughout.
// 2. E_l=0x0100, g_leak=0x0200, currents 0
//    -> vmem_out = 0x0080, 0x00C0, 0x00E0, 0x00F0 ... converging on 0x0100.
// 3. g_leak=0, all currents 0x0010 from cycle t
//    -> vmem first changes at t+2, rising +4 per cycle; 0x0028 after 10 updates.
// 4. g_leak=0, all currents 0x7FFF
//    -> vmem saturates at 0x7FFF and holds.
//    Then all currents 0x8000
//    -> vmem saturates at 0x8000, with no wrap.
// 5. PLATEAU_EN, E_l=0, v_thresh=0x0200, v_plateau=0x0300, t_plateau=5, t_refrac=3
//    - Drive vmem past 0x0200
//      -> one spike pulse, vmem=0x0300 for 5 cycles, then 0 for 3 cycles, then integration.
//    - Reset asserted in the 3rd plateau cycle -> IDLE, vmem=0 next edge.
// 6. Macro undefined, same configuration as 5
//    -> vmem rises past 0x0200 and keeps integrating; dendritic_spike stays 0.

Source files
------------

// File: rtl/dendrite_compartment.sv
// rtl/dendrite_compartment.sv - leaky dendritic integrator with optional plateau FSM (macro DENDRITE_PLATEAU_EN)
module dendrite_compartment #(
    parameter int NUM_SYN       = 4,
    parameter int LEAK_SHIFT    = 10,
    parameter int CURRENT_SHIFT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SYN*16-1:0] syn_current_i,
    output logic [NUM_SYN*16-1:0] syn_vmem_o,
    input  logic                  cfg_data_clk_i,
    input  logic                  cfg_data_in_i,
    output logic                  cfg_data_clk_o,
    output logic                  cfg_data_in_o,
    output logic [15:0]           vmem_out_o,
    output logic                  dendritic_spike_o
);
    localparam int SUM_W = 16 + $clog2(NUM_SYN);
    localparam int CFG_W = 96;
    localparam int ACC_W = 36;

    // Chain layout, input end first: E_l, g_leak, v_thresh, v_plateau, t_plateau, t_refrac.
    logic [CFG_W-1:0] cfg_chain_q;

    always_ff @(posedge cfg_data_clk_i) begin
        cfg_chain_q <= {cfg_chain_q[CFG_W-2:0], cfg_data_in_i};
    end

    assign cfg_data_clk_o = cfg_data_clk_i;
    assign cfg_data_in_o  = cfg_chain_q[CFG_W-1];

    logic signed [15:0] e_l;
    logic        [15:0] g_leak;
    assign e_l    = cfg_chain_q[15:0];
    assign g_leak = cfg_chain_q[31:16];

    logic signed [SUM_W-1:0] i_sum_d;
    logic signed [SUM_W-1:0] i_sum_q;

    always_comb begin
        i_sum_d = '0;
        for (int k = 0; k < NUM_SYN; k++) begin
            i_sum_d = i_sum_d + SUM_W'(signed'(syn_current_i[k*16 +: 16]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_sum_q <= '0;
        end else begin
            i_sum_q <= i_sum_d;
        end
    end

    logic signed [15:0]      vmem_q;
    logic signed [15:0]      vmem_d;
    logic signed [16:0]      diff;
    logic signed [16:0]      g_ext;
    logic signed [33:0]      leak_prod;
    logic signed [ACC_W-1:0] acc;

    assign diff      = {e_l[15], e_l} - {vmem_q[15], vmem_q};
    assign g_ext     = {1'b0, g_leak};
    assign leak_prod = 34'(diff) * 34'(g_ext);
    assign acc       = ACC_W'(vmem_q) + ACC_W'(leak_prod >>> LEAK_SHIFT)
                     + ACC_W'(i_sum_q >>> CURRENT_SHIFT);

    always_comb begin
        if (acc > ACC_W'(32767)) begin
            vmem_d = 16'sh7FFF;
        end else if (acc < ACC_W'(-32768)) begin
            vmem_d = 16'sh8000;
        end else begin
            vmem_d = acc[15:0];
        end
    end

`ifdef DENDRITE_PLATEAU_EN
    typedef enum logic [1:0] {IDLE, PLATEAU, REFRACT} state_t;

    logic signed [15:0] v_thresh;
    logic signed [15:0] v_plateau;
    logic        [15:0] t_plateau;
    logic        [15:0] t_refrac;
    assign v_thresh  = cfg_chain_q[47:32];
    assign v_plateau = cfg_chain_q[63:48];
    assign t_plateau = cfg_chain_q[79:64];
    assign t_refrac  = cfg_chain_q[95:80];

    state_t      state_q;
    logic [15:0] counter_q;
    logic        spike_q;

    // Leaving REFRACT integrates from vmem_q, which is already held at E_l.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            vmem_q    <= '0;
            counter_q <= '0;
            spike_q   <= 1'b0;
        end else begin
            spike_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (vmem_q >= v_thresh) begin
                        state_q   <= PLATEAU;
                        vmem_q    <= v_plateau;
                        counter_q <= t_plateau;
                        spike_q   <= 1'b1;
                    end else begin
                        vmem_q <= vmem_d;
                    end
                end
                PLATEAU: begin
                    if (counter_q <= 16'd1) begin
                        state_q   <= REFRACT;
                        vmem_q    <= e_l;
                        counter_q <= t_refrac;
                    end else begin
                        vmem_q    <= v_plateau;
                        counter_q <= counter_q - 16'd1;
                    end
                end
                REFRACT: begin
                    if (counter_q <= 16'd1) begin
                        state_q   <= IDLE;
                        vmem_q    <= vmem_d;
                        counter_q <= '0;
                    end else begin
                        vmem_q    <= e_l;
                        counter_q <= counter_q - 16'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    vmem_q    <= '0;
                    counter_q <= '0;
                end
            endcase
        end
    end

    assign dendritic_spike_o = spike_q;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            vmem_q <= '0;
        end else begin
            vmem_q <= vmem_d;
        end
    end

    assign dendritic_spike_o = 1'b0;
`endif

    assign vmem_out_o = vmem_q;
    assign syn_vmem_o = {NUM_SYN{vmem_q}};

endmodule

// File: tb/tb_dendrite_compartment.sv
// tb/tb_dendrite_compartment.sv - directed self-checking bench for dendrite_compartment
module tb_dendrite_compartment;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] syn_current = '0;
    logic [63:0] syn_vmem;
    logic        cfg_clk = 1'b0;
    logic        cfg_din = 1'b0;
    logic        cfg_clk_out;
    logic        cfg_dout;
    logic [15:0] vmem_out;
    logic        spike;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dendrite_compartment #(
        .NUM_SYN(4),
        .LEAK_SHIFT(10),
        .CURRENT_SHIFT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .syn_current_i(syn_current),
        .syn_vmem_o(syn_vmem),
        .cfg_data_clk_i(cfg_clk),
        .cfg_data_in_i(cfg_din),
        .cfg_data_clk_o(cfg_clk_out),
        .cfg_data_in_o(cfg_dout),
        .vmem_out_o(vmem_out),
        .dendritic_spike_o(spike)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input logic [15:0] v);
        syn_current = {4{v}};
    endtask

    task automatic load_cfg(input logic [15:0] e, input logic [15:0] g, input logic [15:0] vt,
                            input logic [15:0] vp, input logic [15:0] tp, input logic [15:0] tr);
        logic [95:0] bits;
        bits = {tr, tp, vp, vt, g, e};
        for (int i = 95; i >= 0; i--) begin
            cfg_din = bits[i];
            #1 cfg_clk = 1'b1;
            #1 cfg_clk = 1'b0;
        end
    endtask

    // Reset for two edges with the given configuration, then release.
    task automatic restart(input logic [15:0] cur, input logic [15:0] e, input logic [15:0] g,
                           input logic [15:0] vt, input logic [15:0] vp,
                           input logic [15:0] tp, input logic [15:0] tr);
        reset = 1'b1;
        set_cur(cur);
        load_cfg(e, g, vt, vp, tp, tr);
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        // Reset with non-zero currents
        set_cur(16'h0100);
        load_cfg(16'h0100, 16'h0200, 16'h7FFF, 16'h0000, 16'd5, 16'd3);
        step(1);
        check("rst_vmem_c1", 32'(vmem_out), 32'h0);
        check("rst_spike_c1", 32'(spike), 32'h0);
        step(1);
        check("rst_vmem_c2", 32'(vmem_out), 32'h0);
        check("rst_spike_c2", 32'(spike), 32'h0);
        check("rst_cfg_clk_out", 32'(cfg_clk_out), 32'h0);

        // Leak toward E_l
        restart(16'h0000, 16'h0100, 16'h0200, 16'h7FFF, 16'h0000, 16'd5, 16'd3);
        step(1); check("leak_1", 32'(vmem_out), 32'h0080);
        step(1); check("leak_2", 32'(vmem_out), 32'h00C0);
        step(1); check("leak_3", 32'(vmem_out), 32'h00E0);
        step(1); check("leak_4", 32'(vmem_out), 32'h00F0);
        check("leak_syn3_vmem", 32'(syn_vmem[63:48]), 32'h00F0);
        check("leak_syn0_vmem", 32'(syn_vmem[15:0]), 32'h00F0);
        step(4); check("leak_8", 32'(vmem_out), 32'h00FF);
        step(1); check("leak_9", 32'(vmem_out), 32'h00FF);

        // Two-edge latency, +4 per update
        restart(16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'd5, 16'd3);
        step(2); check("lat_idle", 32'(vmem_out), 32'h0);
        set_cur(16'h0010);
        step(1); check("lat_t1", 32'(vmem_out), 32'h0);
        step(1); check("lat_t2", 32'(vmem_out), 32'h0004);
        step(1); check("lat_t3", 32'(vmem_out), 32'h0008);
        step(8); check("lat_t11", 32'(vmem_out), 32'h0028);

        // Saturation both ways without wrap
        restart(16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'd5, 16'd3);
        step(2); check("neg_e2", 32'(vmem_out), 32'hE000);
        step(3); check("neg_e5", 32'(vmem_out), 32'h8000);
        step(1); check("neg_e6", 32'(vmem_out), 32'h8000);
        step(1); check("neg_e7", 32'(vmem_out), 32'h8000);
        set_cur(16'h7FFF);
        step(1); check("pos_e8", 32'(vmem_out), 32'h8000);
        step(1); check("pos_e9", 32'(vmem_out), 32'h9FFF);
        step(7); check("pos_e16", 32'(vmem_out), 32'h7FF8);
        step(1); check("pos_e17", 32'(vmem_out), 32'h7FFF);
        step(1); check("pos_e18", 32'(vmem_out), 32'h7FFF);
`ifdef DENDRITE_PLATEAU_EN
        check("pos_e18_spike", 32'(spike), 32'h1);
`else
        check("pos_e18_spike", 32'(spike), 32'h0);
`endif
        step(1); check("pos_e19", 32'(vmem_out), 32'h7FFF);
        check("pos_e19_spike", 32'(spike), 32'h0);

        // Threshold scenario: +0x20 per update from 0
        restart(16'h0080, 16'h0000, 16'h0000, 16'h0200, 16'h0300, 16'd5, 16'd3);
        step(1); check("thr_e1", 32'(vmem_out), 32'h0);
        step(16); check("thr_e17", 32'(vmem_out), 32'h0200);
        check("thr_e17_spike", 32'(spike), 32'h0);
`ifdef DENDRITE_PLATEAU_EN
        step(1); check("plat_e18", 32'(vmem_out), 32'h0300);
        check("plat_e18_spike", 32'(spike), 32'h1);
        step(1); check("plat_e19", 32'(vmem_out), 32'h0300);
        check("plat_e19_spike", 32'(spike), 32'h0);
        step(3); check("plat_e22", 32'(vmem_out), 32'h0300);
        step(1); check("refr_e23", 32'(vmem_out), 32'h0);
        step(2); check("refr_e25", 32'(vmem_out), 32'h0);
        step(1); check("resume_e26", 32'(vmem_out), 32'h0020);
        check("resume_e26_spike", 32'(spike), 32'h0);
        step(15); check("retrig_e41", 32'(vmem_out), 32'h0200);
        step(1); check("retrig_e42", 32'(vmem_out), 32'h0300);
        check("retrig_e42_spike", 32'(spike), 32'h1);
        step(2); check("retrig_e44", 32'(vmem_out), 32'h0300);
        reset = 1'b1;
        step(1); check("midrst_vmem", 32'(vmem_out), 32'h0);
        check("midrst_spike", 32'(spike), 32'h0);
        reset = 1'b0;
        step(2); check("midrst_idle", 32'(vmem_out), 32'h0020);
`else
        for (int e = 18; e <= 25; e++) begin
            step(1);
            check("noplat_spike", 32'(spike), 32'h0);
            check("noplat_vmem", 32'(vmem_out), 32'((e - 1) * 32));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
